// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, word-length codes and oversample constants.
// The receiver imports the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int OSM_13 = 13;
    localparam int OSM_16 = 16;

    // Keeps only the data bits that belong to the selected word length.
    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        case (wls)
            WLS_5:   return 8'h1F;
            WLS_6:   return 8'h3F;
            WLS_7:   return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable modulo-(limit+1) counter; bit_end pulses in the last cycle of each bit period.
// load holds the count at zero so the first period after release is a full bit.
module uart_bit_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] limit,
    output logic       bit_end
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= 4'd0;
        end else if (cnt == limit) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign bit_end = (cnt == limit) && !load;

endmodule

// File: rtl/transmitter_timing_and_shift_register.sv
// UART transmit engine: accepts one word per valid/ready handshake and serialises it as
// start, LSB-first data, optional parity and 1-2 stop bits on tx.
module transmitter_timing_and_shift_register
    import uart_pkg::*;
#(
    parameter int OSM_13 = uart_pkg::OSM_13,
    parameter int OSM_16 = uart_pkg::OSM_16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EPS,
    input  logic        PEN,
    input  logic        SP,
    input  logic [1:0]  WLS,
    input  logic        STB,
    input  logic        osm_sel,
    input  logic [7:0]  data_tx,
    input  logic        valid_tx,
    output logic        ready_tx,
    output logic        tx,
    output logic        busy_tx,
    output logic        done_tx,
    output uart_state_t state
);

    // Handshake: a word transfers on a clk edge where valid_tx and ready_tx are both high;
    // ready_tx is high only in IDLE, and all line settings are sampled on that same edge.

    uart_state_t state_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [2:0]  last_idx, last_idx_n;
    logic        pen_q, pen_n;
    logic        par_q, par_n;
    logic        stb_q, stb_n;
    logic        osm_q, osm_n;
    logic        stop_idx, stop_idx_n;
    logic        tx_n, done_n;
    logic [7:0]  masked;
    logic [3:0]  limit;
    logic        bit_end;

    assign limit  = osm_q ? 4'(OSM_16 - 1) : 4'(OSM_13 - 1);
    assign masked = data_tx & word_mask(WLS);

    uart_bit_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (state == IDLE),
        .limit   (limit),
        .bit_end (bit_end)
    );

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_idx_n  = bit_idx;
        last_idx_n = last_idx;
        pen_n      = pen_q;
        par_n      = par_q;
        stb_n      = stb_q;
        osm_n      = osm_q;
        stop_idx_n = stop_idx;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (valid_tx) begin
                    state_n    = START;
                    shreg_n    = masked;
                    bit_idx_n  = 3'd0;
                    last_idx_n = 3'd4 + {1'b0, WLS};
                    pen_n      = PEN;
                    par_n      = SP ? ~EPS : (EPS ? ^masked : ~^masked);
                    stb_n      = STB;
                    osm_n      = osm_sel;
                    stop_idx_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_idx == last_idx) begin
                        state_n = pen_q ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == stb_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered, so it is derived from where the FSM is going next.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            last_idx <= 3'd0;
            pen_q    <= 1'b0;
            par_q    <= 1'b0;
            stb_q    <= 1'b0;
            osm_q    <= 1'b0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            ready_tx <= 1'b1;
            busy_tx  <= 1'b0;
            done_tx  <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_idx_n;
            last_idx <= last_idx_n;
            pen_q    <= pen_n;
            par_q    <= par_n;
            stb_q    <= stb_n;
            osm_q    <= osm_n;
            stop_idx <= stop_idx_n;
            tx       <= tx_n;
            ready_tx <= (state_n == IDLE);
            busy_tx  <= (state_n != IDLE);
            done_tx  <= done_n;
        end
    end

endmodule
